octal_onehot_driver: RTL and testbench

- Inverse of the team's 8-to-3 one-hot-to-binary octal encoder.
- Accepts 3-bit binary codes over a valid/ready handshake and drives the matching 8-bit one-hot word.
- The one-hot word uses the same bit order as the encoder: code 0 maps to bit 7, code 7 maps to bit 0.
- Each word is held for a programmable number of cycles, followed by an all-zero gap, so a downstream encoder or load sees clean, non-overlapping one-hot strobes.

---
 rtl/octal_pkg.sv | 49 ++++
 rtl/octal_onehot_driver_if.sv | 23 ++
 rtl/octal_onehot_driver.sv | 109 ++++++++++
 tb/tb_octal_onehot_driver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/octal_pkg.sv
// Shared types and helpers for the octal one-hot driver and its companion encoder.
// Bit order matches the encoder: code 0 is bit 7, code 7 is bit 0.
package octal_pkg;

  localparam int OCT_W    = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } oct_state_e;

  function automatic logic [ONEHOT_W-1:0] oct_decode(input logic [OCT_W-1:0] code);
    logic [ONEHOT_W-1:0] word;
    word = 8'h00;
    case (code)
      3'd0:    word = 8'b1000_0000;
      3'd1:    word = 8'b0100_0000;
      3'd2:    word = 8'b0010_0000;
      3'd3:    word = 8'b0001_0000;
      3'd4:    word = 8'b0000_1000;
      3'd5:    word = 8'b0000_0100;
      3'd6:    word = 8'b0000_0010;
      3'd7:    word = 8'b0000_0001;
      default: word = 8'h00;
    endcase
    return word;
  endfunction

  // Non-one-hot inputs fall back to code 0, as the encoder does.
  function automatic logic [OCT_W-1:0] oct_encode(input logic [ONEHOT_W-1:0] onehot);
    logic [OCT_W-1:0] code;
    code = 3'd0;
    case (onehot)
      8'b1000_0000: code = 3'd0;
      8'b0100_0000: code = 3'd1;
      8'b0010_0000: code = 3'd2;
      8'b0001_0000: code = 3'd3;
      8'b0000_1000: code = 3'd4;
      8'b0000_0100: code = 3'd5;
      8'b0000_0010: code = 3'd6;
      8'b0000_0001: code = 3'd7;
      default:      code = 3'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/octal_onehot_driver_if.sv
// Code-in / one-hot-out bundle; the master supplies codes, the slave drives the strobe.
interface octal_onehot_driver_if;
  import octal_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OCT_W-1:0]    in_code;
  logic [ONEHOT_W-1:0] out_onehot;
  logic                out_valid;
  logic                busy;
  logic                done;

  modport master (
    output in_valid, in_code,
    input  in_ready, out_onehot, out_valid, busy, done
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out_onehot, out_valid, busy, done
  );

endinterface

// File: rtl/octal_onehot_driver.sv
// Turns an accepted 3-bit code into a one-hot strobe held HOLD_CYCLES cycles,
// followed by GAP_CYCLES all-zero cycles and one mandatory idle cycle.
module octal_onehot_driver
  import octal_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  octal_onehot_driver_if.slave bus
);

  localparam int MAX_HG   = (HOLD_CYCLES > GAP_CYCLES) ?
                            ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2) :
                            ((GAP_CYCLES  > 2) ? GAP_CYCLES  : 2);
  localparam int CNT_W    = $clog2(MAX_HG);
  localparam int HOLD_LD  = HOLD_CYCLES - 1;
  localparam int GAP_LD   = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("octal_onehot_driver: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("octal_onehot_driver: GAP_CYCLES must be >= 0");
  end

  oct_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ONEHOT_W-1:0] onehot_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  // Sequencer: state, counter and every output are registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_W'(0);
      onehot_q <= 8'h00;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q  <= DRIVE;
            cnt_q    <= CNT_W'(HOLD_LD);
            onehot_q <= oct_decode(bus.in_code);
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= (HOLD_CYCLES == 1);
          end else begin
            state_q  <= IDLE;
            cnt_q    <= CNT_W'(0);
            onehot_q <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt_q == CNT_W'(0)) begin
            onehot_q <= 8'h00;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
              cnt_q   <= CNT_W'(GAP_LD);
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= CNT_W'(0);
              busy_q  <= 1'b0;
            end
          end else begin
            // done is registered, so it rises as the counter reaches zero.
            cnt_q  <= cnt_q - CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(1));
          end
        end
        GAP: begin
          if (cnt_q == CNT_W'(0)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= CNT_W'(0);
          onehot_q <= 8'h00;
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_onehot = onehot_q;
  assign bus.out_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_octal_onehot_driver.sv
// Three driver configurations checked every cycle against a phase-based timeline model,
// plus directed table, timing, back-to-back, churn and reset scenarios.
module tb_octal_onehot_driver;
  import octal_pkg::*;

  localparam int NI = 3;
  localparam int H_ARR [NI] = '{4, 3, 1};
  localparam int G_ARR [NI] = '{1, 2, 0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  octal_onehot_driver_if bus0 ();
  octal_onehot_driver_if bus1 ();
  octal_onehot_driver_if bus2 ();

  octal_onehot_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  octal_onehot_driver #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  octal_onehot_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic       v_in [NI];
  logic [2:0] c_in [NI];
  logic       o_ready [NI];
  logic       o_valid [NI];
  logic       o_busy  [NI];
  logic       o_done  [NI];
  logic [7:0] o_word  [NI];

  assign bus0.in_valid = v_in[0];  assign bus0.in_code = c_in[0];
  assign bus1.in_valid = v_in[1];  assign bus1.in_code = c_in[1];
  assign bus2.in_valid = v_in[2];  assign bus2.in_code = c_in[2];
  assign o_ready[0] = bus0.in_ready; assign o_valid[0] = bus0.out_valid; assign o_busy[0] = bus0.busy;
  assign o_done[0]  = bus0.done;     assign o_word[0]  = bus0.out_onehot;
  assign o_ready[1] = bus1.in_ready; assign o_valid[1] = bus1.out_valid; assign o_busy[1] = bus1.busy;
  assign o_done[1]  = bus1.done;     assign o_word[1]  = bus1.out_onehot;
  assign o_ready[2] = bus2.in_ready; assign o_valid[2] = bus2.out_valid; assign o_busy[2] = bus2.busy;
  assign o_done[2]  = bus2.done;     assign o_word[2]  = bus2.out_onehot;

  int n_cmp = 0;
  int n_bad = 0;
  logic check_en = 1'b0;

  function automatic void chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, got, exp);
    end
  endfunction

  // Timeline model: k counts cycles since the accepting edge; 1..H drive, H+1..H+G gap.
  logic       m_act  [NI];
  int         m_k    [NI];
  logic [2:0] m_code [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
        m_k[i]   <= 0;
      end else if (!m_act[i]) begin
        if (v_in[i]) begin
          m_act[i]  <= 1'b1;
          m_k[i]    <= 1;
          m_code[i] <= c_in[i];
        end
      end else if (m_k[i] + 1 > H_ARR[i] + G_ARR[i]) begin
        m_act[i] <= 1'b0;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NI; i++) begin
        logic       drv;
        logic [7:0] w;
        drv = m_act[i] && (m_k[i] <= H_ARR[i]);
        w   = drv ? (8'h80 >> m_code[i]) : 8'h00;
        chk("in_ready",   i, 16'(o_ready[i]), 16'(!m_act[i]));
        chk("out_valid",  i, 16'(o_valid[i]), 16'(drv));
        chk("out_onehot", i, 16'(o_word[i]),  16'(w));
        chk("busy",       i, 16'(o_busy[i]),  16'(m_act[i]));
        chk("done",       i, 16'(o_done[i]),  16'(m_act[i] && (m_k[i] == H_ARR[i])));
        if (o_valid[i]) chk("roundtrip", i, 16'(oct_encode(o_word[i])), 16'(m_code[i]));
      end
    end
  end

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (m_act[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (m_act[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle[%0d] got=busy exp=idle within 50 cycles", i);
    end
  endtask

  logic [7:0]  tbl [8];
  logic [11:0] pat;

  initial begin
    tbl = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    for (int i = 0; i < NI; i++) begin
      v_in[i] = 1'b0;
      c_in[i] = 3'd0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_onehot", 0, 16'(o_word[0]),  16'h00);
    chk("rst_ready",  1, 16'(o_ready[1]), 16'h1);
    chk("rst_busy",   2, 16'(o_busy[2]),  16'h0);
    rst_n = 1'b1;

    // Full decode table on the default configuration.
    for (int c = 0; c < 8; c++) begin
      wait_idle(0);
      v_in[0] = 1'b1;
      c_in[0] = 3'(c);
      @(negedge clk);
      v_in[0] = 1'b0;
      c_in[0] = 3'($urandom_range(0, 7));
      chk("table", c, 16'(o_word[0]), 16'(tbl[c]));
      repeat (3) @(negedge clk);
      chk("table_done", c, 16'(o_done[0]), 16'h1);
    end

    // Churn: code changes while busy must not disturb the held word.
    wait_idle(0);
    v_in[0] = 1'b1;
    c_in[0] = 3'd3;
    @(negedge clk);
    c_in[0] = 3'd7;
    for (int j = 0; j < 4; j++) begin
      chk("churn_hold", j, 16'(o_word[0]), 16'h10);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("churn_next", 0, 16'(o_word[0]), 16'h01);
    v_in[0] = 1'b0;

    // HOLD=3, GAP=2 with in_valid held: 6-cycle strobe period.
    wait_idle(1);
    v_in[1] = 1'b1;
    c_in[1] = 3'd5;
    for (int j = 11; j >= 0; j--) begin
      @(negedge clk);
      pat[j] = o_valid[1];
    end
    chk("period_pattern", 1, 16'(pat), 16'(12'b111000_111000));
    v_in[1] = 1'b0;

    // HOLD=1, GAP=0 back-to-back codes 2 then 6.
    wait_idle(2);
    v_in[2] = 1'b1;
    c_in[2] = 3'd2;
    @(negedge clk);
    chk("b2b_first", 2, 16'(o_word[2]), 16'h20);
    chk("b2b_done1", 2, 16'(o_done[2]), 16'h1);
    c_in[2] = 3'd6;
    @(negedge clk);
    chk("b2b_idle", 2, 16'(o_word[2]), 16'h00);
    @(negedge clk);
    chk("b2b_second", 2, 16'(o_word[2]), 16'h02);
    chk("b2b_done2",  2, 16'(o_done[2]), 16'h1);
    v_in[2] = 1'b0;

    // Reset on the second DRIVE cycle kills the strobe at once.
    wait_idle(0);
    v_in[0] = 1'b1;
    c_in[0] = 3'd1;
    @(negedge clk);
    v_in[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_onehot", 0, 16'(o_word[0]),  16'h00);
    chk("mid_rst_ready",  0, 16'(o_ready[0]), 16'h1);
    rst_n = 1'b1;

    // Random traffic with occasional reset.
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        v_in[i] = ($urandom_range(0, 3) != 0);
        c_in[i] = 3'($urandom_range(0, 7));
      end
      rst_n = ($urandom_range(0, 79) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
